// File: rtl/rr_mux4_pkg.sv
// Shared constants and helpers for the four-channel round-robin mux.
package rr_mux4_pkg;

   localparam int N_CH  = 4;
   localparam int IDX_W = 2;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/rr_mux4_arb4.sv
// Combinational 4-way round-robin priority select starting at ptr.
module rr_arb4
   import rr_mux4_pkg::*;
(
   input  logic [N_CH-1:0]  request,
   input  logic [IDX_W-1:0] ptr,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      cand        = ptr;
      for (int k = 0; k < N_CH; k++) begin
         cand = ptr + IDX_W'(k);
         if (!grant_valid && request[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_mux4.sv
// Four-channel round-robin multiplexer with a registered output beat,
// source-index outputs for a downstream demux and a completed-beat counter.
module rr_mux4
   import rr_mux4_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  s1,
   output logic                  s0,
   output logic [CNT_W-1:0]      beat_cnt
);

   // Handshakes: a beat moves when valid and ready are both high on a rising
   // edge; valid never waits for ready, and ready here is combinational.
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] src_idx;
   logic             load;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

   assign load = !out_valid || out_ready;

   rr_arb4 u_arb (
      .request     (in_valid),
      .ptr         (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      in_ready = '0;
      if (!rst && load && grant_valid)
         in_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         src_idx   <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
      end else begin
         if (out_valid && out_ready)
            beat_cnt <= beat_cnt + CNT_W'(1);
         if (load) begin
            if (grant_valid) begin
               out_valid <= 1'b1;
               out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
               src_idx   <= grant_idx;
               rr_ptr    <= next_idx(grant_idx);
            end else begin
               // Idle load: drop valid but keep data/index/pointer as they were.
               out_valid <= 1'b0;
            end
         end
      end
   end

   assign s1 = src_idx[1];
   assign s0 = src_idx[0];

endmodule
